// File: rtl/dcpu_bus_pkg.sv
// Shared types and constants for the dcpu cs/we/ack bus.
// Used by the arbiter and its watchdog.
package dcpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS_M0  = 2'd1,
      BUS_M1  = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam logic [1:0]  GRANT_NONE = 2'b00;
   localparam logic [1:0]  GRANT_M0   = 2'b01;
   localparam logic [1:0]  GRANT_M1   = 2'b10;

   localparam logic [15:0] DEFAULT_ERR_DATA = 16'hDEAD;

   // The counter keeps at least 8 bits even for short timeouts.
   function automatic int wd_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-hang watchdog: counts granted cycles without a slave ack and pulses
// expire on the last allowed cycle. TIMEOUT = 0 disables it.
module bus_watchdog
   import dcpu_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   input  logic ack,
   output logic expire
);

   localparam int CW = wd_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit ENABLED = (TIMEOUT != 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || !ENABLED) begin
         count <= '0;
      end else if (run && !ack) begin
         count <= count + 1'b1;
      end
   end

   // A same-cycle ack always beats expiry.
   assign expire = ENABLED && run && !ack && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / one-slave arbiter for the dcpu 16-bit cs/we/ack bus, with a
// bus-hang watchdog. Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module bus_arbiter
   import dcpu_bus_pkg::*;
#(
   parameter int             AW       = 16,
   parameter int             DW       = 16,
   parameter int             TIMEOUT  = 255,
   parameter logic [DW-1:0]  ERR_DATA = DW'(DEFAULT_ERR_DATA)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_dat,
   output logic [DW-1:0] o_m0_dat,
   input  logic          i_m0_we,
   input  logic          i_m0_cs,
   output logic          o_m0_ack,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_dat,
   output logic [DW-1:0] o_m1_dat,
   input  logic          i_m1_we,
   input  logic          i_m1_cs,
   output logic          o_m1_ack,
   output logic [AW-1:0] o_s_addr,
   output logic [DW-1:0] o_s_dat,
   input  logic [DW-1:0] i_s_dat,
   output logic          o_s_we,
   output logic          o_s_cs,
   input  logic          i_s_ack,
   output logic [1:0]    o_grant,
   output logic          o_timeout
);

   arb_state_t state, state_next;
   logic in_bus;
   logic cur_cs;
   logic expire;
   logic timeout_hit;
   logic prefer_m1;

   assign in_bus      = (state == BUS_M0) || (state == BUS_M1);
   assign cur_cs      = (state == BUS_M1) ? i_m1_cs : i_m0_cs;
   // An aborting master gets no ack, not even a forced one.
   assign timeout_hit = in_bus && cur_cs && expire;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (i_clk),
      .rst_n  (i_reset_n),
      .clear  (!in_bus),
      .run    (in_bus),
      .ack    (i_s_ack),
      .expire (expire)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic last_m1;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         last_m1 <= 1'b1;
      end else if (state == IDLE && state_next != IDLE) begin
         last_m1 <= (state_next == BUS_M1);
      end
   end

   assign prefer_m1 = !last_m1;
`else
   assign prefer_m1 = 1'b1;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_m1_cs && (!i_m0_cs || prefer_m1)) begin
               state_next = BUS_M1;
            end else if (i_m0_cs) begin
               state_next = BUS_M0;
            end
         end
         BUS_M0: begin
            if (i_s_ack || !i_m0_cs || expire) begin
               state_next = RELEASE;
            end
         end
         BUS_M1: begin
            if (i_s_ack || !i_m1_cs || expire) begin
               state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_s_cs   = 1'b0;
      o_s_we   = 1'b0;
      o_s_addr = '0;
      o_s_dat  = '0;
      o_grant  = GRANT_NONE;
      o_m0_ack = 1'b0;
      o_m1_ack = 1'b0;
      o_m0_dat = '0;
      o_m1_dat = '0;
      case (state)
         BUS_M0: begin
            o_s_cs   = 1'b1;
            o_s_we   = i_m0_we;
            o_s_addr = i_m0_addr;
            o_s_dat  = i_m0_dat;
            o_grant  = GRANT_M0;
            o_m0_ack = i_s_ack || timeout_hit;
            o_m0_dat = timeout_hit ? ERR_DATA : i_s_dat;
         end
         BUS_M1: begin
            o_s_cs   = 1'b1;
            o_s_we   = i_m1_we;
            o_s_addr = i_m1_addr;
            o_s_dat  = i_m1_dat;
            o_grant  = GRANT_M1;
            o_m1_ack = i_s_ack || timeout_hit;
            o_m1_dat = timeout_hit ? ERR_DATA : i_s_dat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_timeout <= 1'b0;
      end else if (timeout_hit) begin
         o_timeout <= 1'b1;
      end
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the dcpu 16-bit cs/we/ack bus.
- Sits directly upstream of the system's external bus port.
- Master 0 is the dcpu core. Master 1 is the UART debug master (memory load/inspect).
- Slave side drives the single external memory/peripheral bus. Includes a bus-hang watchdog that terminates unacknowledged cycles.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, cycles a granted transfer may wait for i_s_ack before forced termination; 0 disables the watchdog.
- ERR_DATA, 16'hDEAD, read data returned on a timed-out transfer.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_m0_addr  in  AW  master 0 address.
- i_m0_dat  in  DW  master 0 write data.
- o_m0_dat  out  DW  master 0 read data.
- i_m0_we  in  1  master 0 write enable.
- i_m0_cs  in  1  master 0 request, held until ack.
- o_m0_ack  out  1  master 0 transfer done, one-cycle pulse.
- i_m1_addr, i_m1_dat, o_m1_dat, i_m1_we, i_m1_cs, o_m1_ack: same as master 0, for master 1.
- o_s_addr  out  AW  slave address.
- o_s_dat  out  DW  slave write data.
- i_s_dat  in  DW  slave read data.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave select.
- i_s_ack  in  1  slave done.
- o_grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset_n is asynchronous, active-low.
- Reset values: state IDLE; o_grant 0; o_s_cs 0; o_s_we 0; o_s_addr 0; o_s_dat 0; o_m0_ack and o_m1_ack 0; o_m0_dat and o_m1_dat 0; watchdog counter 0; o_timeout 0.
- Reset mid-transfer drops o_s_cs immediately (asynchronous). No ack is issued to either master.
- State machine, registered: IDLE, BUS_M0, BUS_M1, RELEASE.
- IDLE transitions:
  - m1 cs only → BUS_M1.
  - m0 cs only → BUS_M0.
  - both → winner per priority rule.
  - none → stay in IDLE.
- Latency: master cs rising to o_s_cs high is 1 cycle.
- BUS_Mx outputs:
  - o_s_cs = 1.
  - o_s_addr, o_s_dat, o_s_we mux combinationally from master x.
  - o_grant = one-hot x.
- Ack and read data routing:
  - i_s_ack passes combinationally to o_mx_ack.
  - o_mx_dat = i_s_dat while x is granted.
  - The non-granted master always sees ack 0 and data 0.
- BUS_Mx exits:
  - i_s_ack → RELEASE.
  - i_mx_cs dropped without ack (abort) → RELEASE; no ack issued.
- RELEASE: one idle bus cycle. o_s_cs = 0, o_grant = 0, then → IDLE. The granted master therefore cannot re-win in the cycle it drops cs.
- Watchdog counter:
  - 8+ bits, width = clog2(TIMEOUT + 1).
  - Cleared on entry to BUS_Mx; increments each BUS_Mx cycle without ack.
- Watchdog expiry (count == TIMEOUT - 1 with no i_s_ack):
  - Arbiter drives o_mx_ack = 1 and o_mx_dat = ERR_DATA for that cycle.
  - Sets o_timeout; goes to RELEASE.
- i_s_ack and expiry in the same cycle: the ack wins. Slave data is returned and o_timeout is not set.
- o_timeout stays set until reset.
- TIMEOUT = 0: the counter is held at 0 and never fires.
- A late i_s_ack arriving in RELEASE or IDLE is ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-owner register, reset to m1, is updated on each grant. On simultaneous requests, the master not granted last wins.
- Undefined: fixed priority, m1 (debug) always wins; the last-owner register is absent.
- All other behaviour is identical in both builds.

Decomposition:
- Package dcpu_bus_pkg:
  - arb_state_t enum (IDLE, BUS_M0, BUS_M1, RELEASE).
  - GRANT_M0 = 2'b01, GRANT_M1 = 2'b10.
  - Default ERR_DATA constant.
- One natural sub-module: bus_watchdog. Inputs: clear, run, ack. Output: expire pulse. Parameter TIMEOUT.

Test Plan:
- m0 read 16'h0100, slave acks 3 cycles after o_s_cs with 16'h1234 → o_m0_ack 1 cycle, o_m0_dat 16'h1234, o_grant 01, then 1-cycle RELEASE gap.
- m0 and m1 cs in same cycle, m1 write 16'hFFFE = 16'h00AA → m1 granted first; m0 served after RELEASE; o_m0_ack stays low during m1 transfer. With ARB_ROUND_ROBIN_EN: a second simultaneous pair grants m0 first.
- TIMEOUT = 4, slave never acks → o_m0_ack on the 4th BUS_M0 cycle, o_m0_dat 16'hDEAD, o_timeout 1 and stays 1 across later good transfers.
- TIMEOUT = 4, i_s_ack on exactly the 4th cycle → normal data returned, o_timeout remains 0.
- m0 drops cs before ack → o_s_cs low next cycle, no o_m0_ack. A stray i_s_ack in RELEASE produces no master ack.
- i_reset_n pulsed low mid BUS_M1 → o_s_cs, o_grant, o_timeout 0 asynchronously. The arbiter resumes from IDLE and re-arbitrates a still-held request.
